// File: rtl/bcd_pkg.sv
// Shared BCD definitions for the display path.
// Holds the BCD digit width, the double-dabble correction constants and the
// converter FSM state encoding. The BCD-to-seven-segment decoder reuses
// BCD_DIGIT_W from here.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_THRESH = 4'd5;
  localparam logic [BCD_DIGIT_W-1:0] BCD_ADJ_ADD    = 4'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Combinational double-dabble correction cell for one BCD digit.
// Ports:
//   din  - working digit before the shift (0..9 in normal operation)
//   dout - din + 3 when din >= 5, otherwise din
// The add is 4-bit modular; with a legal digit (<= 9) it never wraps.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] din,
  output logic [BCD_DIGIT_W-1:0] dout
);

  assign dout = (din >= BCD_ADJ_THRESH) ? din + BCD_ADJ_ADD : din;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one bit per clock.
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - conversion request, taken only while idle (incl. done cycle)
//   bin      - WIDTH-bit unsigned operand, captured on the accepting edge
//   busy     - high while a conversion is in progress
//   done     - one-cycle pulse when bcd/overflow are updated
//   bcd      - DIGITS packed BCD digits, digit 0 in bcd[3:0]; holds last result
//   overflow - last value exceeded 10^DIGITS-1 (bcd keeps the low digits)
module bin_to_bcd
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 15,
  parameter int DIGITS = 5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [WIDTH-1:0]            bin,
  output logic                        busy,
  output logic                        done,
  output logic [BCD_DIGIT_W*DIGITS-1:0] bcd,
  output logic                        overflow
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   bin_sr_q, bin_sr_d;
  logic [BCD_W-1:0]   bcd_wk_q, bcd_wk_d;
  logic               ovf_acc_q, ovf_acc_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;
  logic [BCD_W-1:0]   bcd_adj;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .din  (bcd_wk_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .dout (bcd_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_sr_d  = bin_sr_q;
    bcd_wk_d  = bcd_wk_q;
    ovf_acc_d = ovf_acc_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SHIFT;
          bin_sr_d  = bin;
          bcd_wk_d  = '0;
          cnt_d     = CNT_W'(WIDTH);
          ovf_acc_d = 1'b0;
        end
      end
      SHIFT: begin
        // Shift {corrected BCD, binary} left by one; the bit leaving the top
        // digit is a lost decimal carry, i.e. the value does not fit.
        bcd_wk_d  = {bcd_adj[BCD_W-2:0], bin_sr_q[WIDTH-1]};
        bin_sr_d  = {bin_sr_q[WIDTH-2:0], 1'b0};
        ovf_acc_d = ovf_acc_q | bcd_adj[BCD_W-1];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          bcd_d   = bcd_wk_d;
          ovf_d   = ovf_acc_d;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bin_sr_q  <= '0;
      bcd_wk_q  <= '0;
      ovf_acc_q <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_sr_q  <= bin_sr_d;
      bcd_wk_q  <= bcd_wk_d;
      ovf_acc_q <= ovf_acc_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign busy     = (state_q == SHIFT);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = ovf_q;

endmodule
